// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit single-cycle CPU: operand widths and ALU control codes.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctrl_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: forces index 0 to zero and, when
// REGFILE_BYPASS_EN is defined, forwards same-cycle writeback data.
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data};
`endif

  always_comb begin
    data = stored;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == addr)) data = wr_data;
`endif
    // Reset masking also keeps the bypass path from forwarding during reset.
    if (rst || (addr == '0)) data = '0;
  end

endmodule

// File: rtl/register_file.sv
// 8 x 16-bit CPU register file, two combinational read ports, one synchronous write port.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_wdata,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_en;

  // Writes to index 0 are dropped so the stored entry stays zero.
  assign wr_en = reg_write && (rd_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rd_addr] = rd_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
    .rst     (rst),
    .addr    (rs_addr),
    .stored  (regs_q[rs_addr]),
    .wr_en   (wr_en),
    .wr_addr (rd_addr),
    .wr_data (rd_wdata),
    .data    (rs_data)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
    .rst     (rst),
    .addr    (rt_addr),
    .stored  (regs_q[rt_addr]),
    .wr_en   (wr_en),
    .wr_addr (rd_addr),
    .wr_data (rd_wdata),
    .data    (rt_data)
  );

endmodule
